bip_control_unit: RTL and testbench

- Multi-cycle control unit for the BIP I accumulator processor; sits directly upstream of the accumulator register and its input multiplexer.
- Holds PC and instruction register, and sequences each instruction through FETCH/DECODE/EXECUTE.
- Drives the accumulator-write strobe, accumulator-source select, ALU op and data-memory strobes; the datapath samples them on the falling clock edge mid-EXECUTE.

---
 rtl/bip_pkg.sv | 64 ++++++
 rtl/bip_decoder.sv | 85 ++++++++
 rtl/bip_control_unit.sv | 148 ++++++++++++++
 tb/tb_bip_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP I control unit: field widths, opcode
// constants, accumulator-source encodings and the sequencer state encoding.
// The optional illegal-opcode trap is selected by BIP_ILLEGAL_TRAP_EN.
package bip_pkg;

  // Instruction field widths (16-bit instruction = opcode | operand)
  localparam int BIP_INSTR_W = 16;
  localparam int BIP_PC_W    = 11;
  localparam int BIP_OPC_W   = 5;
  localparam int BIP_OPD_W   = 11;

  // Opcodes
  localparam logic [BIP_OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [BIP_OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [BIP_OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [BIP_OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [BIP_OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [BIP_OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [BIP_OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [BIP_OPC_W-1:0] OPC_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SELA_ALU = 2'd0;
  localparam logic [1:0] SELA_RAM = 2'd1;
  localparam logic [1:0] SELA_IMM = 2'd2;

  // ALU operand B select and operation
  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;

  // Instruction sequencer states
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // Decoded control bundle for one opcode
  typedef struct packed {
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    wr_acc:  1'b0,
    wr_ram:  1'b0,
    rd_ram:  1'b0,
    sel_a:   SELA_ALU,
    sel_b:   SELB_RAM,
    op:      OP_ADD,
    halt:    1'b0,
    illegal: 1'b0
  };

endpackage

// File: rtl/bip_decoder.sv
// Purely combinational opcode-to-control decoder for the BIP I control unit.
// With BIP_ILLEGAL_TRAP_EN defined, undefined opcodes request a halt and flag
// illegal; otherwise they decode to a NOP (no strobes, no halt).
module bip_decoder
  import bip_pkg::*;
(
  input  logic [BIP_OPC_W-1:0] opcode,
  output logic                 wr_acc,
  output logic                 wr_ram,
  output logic                 rd_ram,
  output logic [1:0]           sel_a,
  output logic                 sel_b,
  output logic                 op,
  output logic                 halt,
  output logic                 illegal
);

  ctrl_t ctrl_s;

  // Map each opcode to its control bundle; unlisted fields stay idle
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (opcode)
      OPC_HLT: begin
        ctrl_s.halt = 1'b1;
      end
      OPC_STO: begin
        ctrl_s.wr_ram = 1'b1;
      end
      OPC_LD: begin
        ctrl_s.rd_ram = 1'b1;
        ctrl_s.sel_a  = SELA_RAM;
        ctrl_s.wr_acc = 1'b1;
      end
      OPC_LDI: begin
        ctrl_s.sel_a  = SELA_IMM;
        ctrl_s.wr_acc = 1'b1;
      end
      OPC_ADD: begin
        ctrl_s.rd_ram = 1'b1;
        ctrl_s.sel_b  = SELB_RAM;
        ctrl_s.op     = OP_ADD;
        ctrl_s.sel_a  = SELA_ALU;
        ctrl_s.wr_acc = 1'b1;
      end
      OPC_ADDI: begin
        ctrl_s.sel_b  = SELB_IMM;
        ctrl_s.op     = OP_ADD;
        ctrl_s.sel_a  = SELA_ALU;
        ctrl_s.wr_acc = 1'b1;
      end
      OPC_SUB: begin
        ctrl_s.rd_ram = 1'b1;
        ctrl_s.sel_b  = SELB_RAM;
        ctrl_s.op     = OP_SUB;
        ctrl_s.sel_a  = SELA_ALU;
        ctrl_s.wr_acc = 1'b1;
      end
      OPC_SUBI: begin
        ctrl_s.sel_b  = SELB_IMM;
        ctrl_s.op     = OP_SUB;
        ctrl_s.sel_a  = SELA_ALU;
        ctrl_s.wr_acc = 1'b1;
      end
      default: begin
`ifdef BIP_ILLEGAL_TRAP_EN
        ctrl_s.halt    = 1'b1;
        ctrl_s.illegal = 1'b1;
`else
        ctrl_s = CTRL_IDLE;
`endif
      end
    endcase
  end

  assign wr_acc  = ctrl_s.wr_acc;
  assign wr_ram  = ctrl_s.wr_ram;
  assign rd_ram  = ctrl_s.rd_ram;
  assign sel_a   = ctrl_s.sel_a;
  assign sel_b   = ctrl_s.sel_b;
  assign op      = ctrl_s.op;
  assign halt    = ctrl_s.halt;
  assign illegal = ctrl_s.illegal;

endmodule

// File: rtl/bip_control_unit.sv
// BIP I multi-cycle control unit: holds PC and IR and walks each instruction
// through FETCH / DECODE / EXECUTE (3 cycles). Datapath strobes come from the
// decoder and are gated so they only appear during EXECUTE; the accumulator
// side samples them on the falling edge mid-EXECUTE.
// Optional feature: BIP_ILLEGAL_TRAP_EN traps undefined opcodes into HALT with
// a sticky Illegal flag; without it they behave as NOPs and Illegal stays 0.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_W  = BIP_PC_W,
  parameter int OPC_W = BIP_OPC_W,
  parameter int OPD_W = BIP_OPD_W
) (
  input  logic             Clock,
  input  logic             Reset_n,
  output logic [PC_W-1:0]  InstrAddr,
  input  logic [15:0]      InstrData,
  output logic [OPD_W-1:0] Operand,
  output logic [15:0]      Imm,
  output logic [1:0]       SelA,
  output logic             SelB,
  output logic             Op,
  output logic             WrAcc,
  output logic             WrRam,
  output logic             RdRam,
  output logic             Halted,
  output logic             Illegal
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;

  logic [OPC_W-1:0]  opcode_s;
  logic              dec_wr_acc_s;
  logic              dec_wr_ram_s;
  logic              dec_rd_ram_s;
  logic [1:0]        dec_sel_a_s;
  logic              dec_sel_b_s;
  logic              dec_op_s;
  logic              dec_halt_s;
  logic              dec_illegal_s;

  assign opcode_s = ir_q[15 -: OPC_W];

  bip_decoder u_decoder (
    .opcode  (opcode_s),
    .wr_acc  (dec_wr_acc_s),
    .wr_ram  (dec_wr_ram_s),
    .rd_ram  (dec_rd_ram_s),
    .sel_a   (dec_sel_a_s),
    .sel_b   (dec_sel_b_s),
    .op      (dec_op_s),
    .halt    (dec_halt_s),
    .illegal (dec_illegal_s)
  );

  // Sequencer state register; reset aborts any instruction in flight
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-step walk, HALT is only left via reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (dec_halt_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Datapath next values: IR loads from ROM in DECODE, PC steps in EXECUTE
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_DECODE: begin
        ir_d = InstrData;
      end
      ST_EXECUTE: begin
        // Natural modulo-2^PC_W wrap from the top address back to 0
        pc_d      = pc_q + PC_W'(1'b1);
        illegal_d = illegal_q | dec_illegal_s;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // PC, IR and sticky illegal flag registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= '0;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode: decoder controls pass through only during EXECUTE
  always_comb begin
    WrAcc  = 1'b0;
    WrRam  = 1'b0;
    RdRam  = 1'b0;
    SelA   = SELA_ALU;
    SelB   = SELB_RAM;
    Op     = OP_ADD;
    if (state_q == ST_EXECUTE) begin
      WrAcc = dec_wr_acc_s;
      WrRam = dec_wr_ram_s;
      RdRam = dec_rd_ram_s;
      SelA  = dec_sel_a_s;
      SelB  = dec_sel_b_s;
      Op    = dec_op_s;
    end else begin
      WrAcc = 1'b0;
      WrRam = 1'b0;
      RdRam = 1'b0;
    end
    Halted = (state_q == ST_HALT);
  end

  assign InstrAddr = pc_q;
  assign Operand   = ir_q[OPD_W-1:0];
  assign Imm       = {{(16 - OPD_W){ir_q[OPD_W-1]}}, ir_q[OPD_W-1:0]};
  // Without the trap the decoder never flags illegal, so this stays 0
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit. A behavioural synchronous ROM
// feeds the DUT; expected EXECUTE-cycle strobe sets are queued per test and
// matched cycle by cycle, every other cycle must be strobe-free.
// Honours BIP_ILLEGAL_TRAP_EN for the undefined-opcode scenario.
module tb_bip_control_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [10:0] InstrAddr;
  logic [15:0] InstrData;
  logic [10:0] Operand;
  logic [15:0] Imm;
  logic [1:0]  SelA;
  logic        SelB, Op, WrAcc, WrRam, RdRam, Halted, Illegal;

  logic [15:0] rom [0:2047];

  typedef struct {
    int          cyc;
    logic [10:0] addr;
    logic        wa, wr, rr;
    logic [1:0]  sela;
    logic        selb, op, chk_alu;
    logic [15:0] imm;
    logic [10:0] operand;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  bip_control_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .InstrAddr(InstrAddr), .InstrData(InstrData),
    .Operand(Operand), .Imm(Imm), .SelA(SelA), .SelB(SelB), .Op(Op),
    .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam), .Halted(Halted), .Illegal(Illegal)
  );

  // Free-running clock
  always #5 Clock = ~Clock;

  // Synchronous program ROM: data valid one cycle after the address
  always @(posedge Clock) InstrData <= rom[InstrAddr];

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) rom[i] = v;
  endtask

  task automatic push_exp(input int cyc, input logic [10:0] addr, input logic wa, input logic wr,
                          input logic rr, input logic [1:0] sela, input logic selb, input logic op,
                          input logic chk_alu, input logic [15:0] imm, input logic [10:0] operand);
    exp_t e;
    e.cyc = cyc; e.addr = addr; e.wa = wa; e.wr = wr; e.rr = rr; e.sela = sela;
    e.selb = selb; e.op = op; e.chk_alu = chk_alu; e.imm = imm; e.operand = operand;
    sb.push_back(e);
  endtask

  // Reset for two edges, release just after a rising edge; next negedge is cycle 1 (FETCH)
  task automatic apply_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
    cycle = 0;
  endtask

  // Advance n cycles, sampling on the falling edge and scoring strobes
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      cycle++;
      checks++;
      if (sb.size() > 0 && sb[0].cyc == cycle) begin
        exp_t e;
        e = sb.pop_front();
        if (WrAcc !== e.wa || WrRam !== e.wr || RdRam !== e.rr || InstrAddr !== e.addr ||
            Operand !== e.operand || Imm !== e.imm || (e.wa && SelA !== e.sela) ||
            (e.chk_alu && (SelB !== e.selb || Op !== e.op))) begin
          failures++;
          $display("FAIL exec_strobes cyc=%0d got wa=%b wr=%b rr=%b sela=%0d selb=%b op=%b addr=%h opd=%h imm=%h expected wa=%b wr=%b rr=%b sela=%0d selb=%b op=%b addr=%h opd=%h imm=%h",
                   cycle, WrAcc, WrRam, RdRam, SelA, SelB, Op, InstrAddr, Operand, Imm,
                   e.wa, e.wr, e.rr, e.sela, e.selb, e.op, e.addr, e.operand, e.imm);
        end
      end else begin
        if ({WrAcc, WrRam, RdRam} !== 3'b000) begin
          failures++;
          $display("FAIL idle_strobes cyc=%0d got wa/wr/rr=%b expected 000", cycle, {WrAcc, WrRam, RdRam});
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drained got %0d pending expected 0 (next cyc=%0d)", name, sb.size(), sb[0].cyc);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    fill_rom(16'h0000);
    Reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if ({WrAcc, WrRam, RdRam, Op, SelB, Halted, Illegal} !== 7'b0000000 || SelA !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctrl got wa=%b wr=%b rr=%b op=%b selb=%b halt=%b ill=%b sela=%0d expected all 0",
               WrAcc, WrRam, RdRam, Op, SelB, Halted, Illegal, SelA);
    end
    checks++;
    if (InstrAddr !== 11'h000 || Operand !== 11'h000 || Imm !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pc_ir got addr=%h opd=%h imm=%h expected 000 000 0000", InstrAddr, Operand, Imm);
    end
  endtask

  task automatic test_immediates();
    fill_rom(16'h0000);
    rom[0] = 16'h1805;  // LDI 5
    rom[1] = 16'h1FFF;  // LDI 0x7FF
    rom[2] = 16'h3C00;  // SUBI 0x400
    rom[3] = 16'h2FFF;  // ADDI -1
    apply_reset();
    push_exp(3,  11'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0005, 11'h005);
    push_exp(6,  11'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'hFFFF, 11'h7FF);
    push_exp(9,  11'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'hFC00, 11'h400);
    push_exp(12, 11'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 11'h7FF);
    run_cycles(3);
    run_cycles(1);
    checks++;
    if (InstrAddr !== 11'd1) begin
      failures++;
      $display("FAIL pc_after_first got %h expected 001", InstrAddr);
    end
    run_cycles(12);
    checks++;
    if (Halted !== 1'b1 || InstrAddr !== 11'd5) begin
      failures++;
      $display("FAIL imm_halt got halted=%b addr=%h expected 1 005", Halted, InstrAddr);
    end
    check_drained("immediates");
  endtask

  task automatic test_program();
    fill_rom(16'h0000);
    rom[0] = 16'h1003;  // LD 3
    rom[1] = 16'h2004;  // ADD 4
    rom[2] = 16'h0805;  // STO 5
    rom[3] = 16'h0000;  // HLT
    rom[4] = 16'h1801;  // must never execute
    apply_reset();
    push_exp(3, 11'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0003, 11'h003);
    push_exp(6, 11'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0004, 11'h004);
    push_exp(9, 11'd2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0005, 11'h005);
    run_cycles(12);
    for (int i = 0; i < 20; i++) begin
      run_cycles(1);
      checks++;
      if (Halted !== 1'b1 || InstrAddr !== 11'd4) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d got halted=%b addr=%h expected 1 004", cycle, Halted, InstrAddr);
      end
    end
    check_drained("program");
  endtask

  task automatic test_pc_wrap();
    logic [10:0] k11;
    for (int k = 0; k < 2048; k++) begin
      k11 = k[10:0];
      rom[k] = {5'b00011, k11};  // LDI k
      push_exp(3 + 3 * k, k11, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, {{5{k11[10]}}, k11}, k11);
    end
    push_exp(3 + 3 * 2048, 11'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h000);
    apply_reset();
    run_cycles(3 * 2048);
    run_cycles(1);
    checks++;
    if (InstrAddr !== 11'h000) begin
      failures++;
      $display("FAIL pc_wrap got %h expected 000", InstrAddr);
    end
    run_cycles(2);
    check_drained("pc_wrap");
  endtask

  task automatic test_async_reset();
    fill_rom(16'h0000);
    rom[0] = 16'h1003;
    rom[1] = 16'h2004;
    rom[2] = 16'h0805;
    rom[3] = 16'h0000;
    apply_reset();
    push_exp(3, 11'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0003, 11'h003);
    push_exp(6, 11'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0004, 11'h004);
    run_cycles(6);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({WrAcc, WrRam, RdRam} !== 3'b000 || InstrAddr !== 11'd0 || Halted !== 1'b0) begin
      failures++;
      $display("FAIL async_abort got wa/wr/rr=%b addr=%h halted=%b expected 000 000 0",
               {WrAcc, WrRam, RdRam}, InstrAddr, Halted);
    end
    apply_reset();
    push_exp(3, 11'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0003, 11'h003);
    push_exp(6, 11'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0004, 11'h004);
    push_exp(9, 11'd2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0005, 11'h005);
    run_cycles(13);
    checks++;
    if (Halted !== 1'b1 || InstrAddr !== 11'd4) begin
      failures++;
      $display("FAIL rerun_halt got halted=%b addr=%h expected 1 004", Halted, InstrAddr);
    end
    check_drained("async_reset");
  endtask

  task automatic test_illegal();
    fill_rom(16'h0000);
    rom[0] = 16'h4000;  // opcode 01000
    rom[1] = 16'h1807;  // LDI 7
    rom[2] = 16'h0000;  // HLT
    apply_reset();
`ifdef BIP_ILLEGAL_TRAP_EN
    run_cycles(4);
    checks++;
    if (Halted !== 1'b1 || Illegal !== 1'b1 || InstrAddr !== 11'd1) begin
      failures++;
      $display("FAIL illegal_trap got halted=%b ill=%b addr=%h expected 1 1 001", Halted, Illegal, InstrAddr);
    end
    run_cycles(6);
    checks++;
    if (Halted !== 1'b1 || Illegal !== 1'b1 || InstrAddr !== 11'd1) begin
      failures++;
      $display("FAIL illegal_sticky got halted=%b ill=%b addr=%h expected 1 1 001", Halted, Illegal, InstrAddr);
    end
`else
    push_exp(6, 11'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0007, 11'h007);
    run_cycles(3);
    checks++;
    if (Illegal !== 1'b0 || Halted !== 1'b0) begin
      failures++;
      $display("FAIL illegal_nop got halted=%b ill=%b expected 0 0", Halted, Illegal);
    end
    run_cycles(1);
    checks++;
    if (InstrAddr !== 11'd1) begin
      failures++;
      $display("FAIL illegal_nop_pc got %h expected 001", InstrAddr);
    end
    run_cycles(6);
    checks++;
    if (Halted !== 1'b1 || Illegal !== 1'b0 || InstrAddr !== 11'd3) begin
      failures++;
      $display("FAIL nop_then_halt got halted=%b ill=%b addr=%h expected 1 0 003", Halted, Illegal, InstrAddr);
    end
`endif
    check_drained("illegal");
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_immediates();
    test_program();
    test_pc_wrap();
    test_async_reset();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
